display_mux: RTL and testbench

Two-digit time-multiplexer that sits directly upstream of the 7-segment decoder on the lab board. It stores the two most recent hex key values, alternates which stored nibble is presented to the decoder, and drives the two common-anode digit enables. Between digit switches it can insert an optional blanking interval with both digits off, to suppress ghosting.

---
 rtl/display_mux_if.sv | 23 ++
 rtl/display_mux.sv | 165 ++++++++++++++++
 tb/tb_display_mux.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/display_mux_if.sv
// Key-entry and display-drive signals of the two-digit display multiplexer.
// The master side supplies hex key values. The slave side (display_mux) returns
// the selected nibble and the active-low digit enables.
interface display_mux_if;
  logic       key_valid;
  logic [3:0] key_num;
  logic [3:0] num;
  logic [1:0] anodes;

  modport master (
    output key_valid,
    output key_num,
    input  num,
    input  anodes
  );

  modport slave (
    input  key_valid,
    input  key_num,
    output num,
    output anodes
  );
endinterface

// File: rtl/display_mux.sv
// display_mux: two-digit time multiplexer placed ahead of the 7-segment decoder.
//
// Behaviour:
//   - Keeps the two most recent hex key values. A new key shifts right into left.
//   - Alternately presents each stored nibble on num.
//   - Drives the matching common-anode enable, active-low.
//
// Optional feature, macro DISPLAY_MUX_BLANKING_EN:
//   - Defined: a both-digits-off interval of BLANK_CYCLES is inserted between
//     showings. This suppresses ghosting.
//   - Undefined: the two digits alternate directly.
//
// Timing notes:
//   - num switches to the upcoming digit on blank entry, so the decoder output
//     settles while both anodes are off.
//   - anodes come straight from flops, so they change only on clock edges.
module display_mux #(
  parameter int REFRESH_CYCLES = 24000,
  parameter int BLANK_CYCLES   = 256
) (
  input  logic         clk,
  input  logic         reset,
  display_mux_if.slave bus
);

  // The counter must hold the longest state duration minus one. Both
  // parameters set the width, even when the blank states are not built.
  localparam int MAX_CYC = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] SHOW_LOAD = CNT_W'(REFRESH_CYCLES - 1);

  localparam logic [1:0] AN_RIGHT = 2'b10;
  localparam logic [1:0] AN_LEFT  = 2'b01;

`ifdef DISPLAY_MUX_BLANKING_EN
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [1:0]       AN_OFF     = 2'b11;

  typedef enum logic [1:0] {
    SHOW_R   = 2'd0,
    BLANK_RL = 2'd1,
    SHOW_L   = 2'd2,
    BLANK_LR = 2'd3
  } state_t;

  // Coming out of reset, the display sits in the blank that precedes the
  // right digit.
  localparam state_t           RESET_STATE = BLANK_LR;
  localparam logic [CNT_W-1:0] RESET_LOAD  = BLANK_LOAD;
  localparam logic [1:0]       RESET_AN    = AN_OFF;
`else
  typedef enum logic {
    SHOW_R = 1'b0,
    SHOW_L = 1'b1
  } state_t;

  localparam state_t           RESET_STATE = SHOW_R;
  localparam logic [CNT_W-1:0] RESET_LOAD  = SHOW_LOAD;
  localparam logic [1:0]       RESET_AN    = AN_RIGHT;
`endif

  logic [3:0]       left;
  logic [3:0]       right;
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [1:0]       anodes_q;
  logic [1:0]       anodes_next;

  // Digit shift register: each new key enters on the right and pushes the
  // old right digit to the left.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      left  <= 4'h0;
      right <= 4'h0;
    end else if (bus.key_valid) begin
      left  <= right;
      right <= bus.key_num;
    end
  end

  // State, dwell counter and digit enables are all registered together.
  // This keeps anodes glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RESET_STATE;
      cnt      <= RESET_LOAD;
      anodes_q <= RESET_AN;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      anodes_q <= anodes_next;
    end
  end

  // Next-state logic.
  //   - While cnt is non-zero, count down in the current state.
  //   - When cnt reaches zero, enter the next state, reload cnt with that
  //     state's duration minus one, and pre-compute its enables.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt - CNT_W'(1);
    anodes_next = anodes_q;
    if (cnt == '0) begin
`ifdef DISPLAY_MUX_BLANKING_EN
      case (state)
        SHOW_R: begin
          state_next  = BLANK_RL;
          cnt_next    = BLANK_LOAD;
          anodes_next = AN_OFF;
        end
        BLANK_RL: begin
          state_next  = SHOW_L;
          cnt_next    = SHOW_LOAD;
          anodes_next = AN_LEFT;
        end
        SHOW_L: begin
          state_next  = BLANK_LR;
          cnt_next    = BLANK_LOAD;
          anodes_next = AN_OFF;
        end
        default: begin
          state_next  = SHOW_R;
          cnt_next    = SHOW_LOAD;
          anodes_next = AN_RIGHT;
        end
      endcase
`else
      case (state)
        SHOW_R: begin
          state_next  = SHOW_L;
          cnt_next    = SHOW_LOAD;
          anodes_next = AN_LEFT;
        end
        default: begin
          state_next  = SHOW_R;
          cnt_next    = SHOW_LOAD;
          anodes_next = AN_RIGHT;
        end
      endcase
`endif
    end
  end

  // Digit select. The blank that leads into a digit already presents that
  // digit, so the decoder output settles before the anode turns on.
  always_comb begin
    bus.num = right;
    case (state)
`ifdef DISPLAY_MUX_BLANKING_EN
      SHOW_R, BLANK_LR: bus.num = right;
      SHOW_L, BLANK_RL: bus.num = left;
`else
      SHOW_R:           bus.num = right;
      SHOW_L:           bus.num = left;
`endif
      default:          bus.num = right;
    endcase
  end

  assign bus.anodes = anodes_q;

endmodule

// File: tb/tb_display_mux.sv
// Randomized self-checking bench for display_mux with REFRESH_CYCLES=8 and
// BLANK_CYCLES=2.
//
// Reference model:
//   - Expected outputs are derived from the position inside the refresh period,
//     counted in edges since reset release.
//   - Digits are a two-entry shift history of the keys.
//   - The same bench also covers builds made without DISPLAY_MUX_BLANKING_EN.
module tb_display_mux;

  localparam int R = 8;
  localparam int B = 2;
`ifdef DISPLAY_MUX_BLANKING_EN
  localparam int B_EFF = B;
`else
  localparam int B_EFF = 0;
`endif
  localparam int P = 2 * (R + B_EFF);

  logic clk;
  logic reset;
  display_mux_if bus ();

  display_mux #(
    .REFRESH_CYCLES (R),
    .BLANK_CYCLES   (B)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_edges  = 0;
  logic [3:0] left_m   = 4'h0;
  logic [3:0] right_m  = 4'h0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected outputs at a given edge count since reset release.
  //   - Period layout: blank before right, right lit, blank before left,
  //     left lit.
  //   - The blank lengths are zero when blanking is absent.
  function automatic void model_out(input int n, output logic [1:0] an, output logic [3:0] nm);
    int p;
    p = n % P;
    if (p < B_EFF) begin
      an = 2'b11;
      nm = right_m;
    end else if (p < B_EFF + R) begin
      an = 2'b10;
      nm = right_m;
    end else if (p < 2 * B_EFF + R) begin
      an = 2'b11;
      nm = left_m;
    end else begin
      an = 2'b01;
      nm = left_m;
    end
  endfunction

  // One clock cycle.
  //   - Entered and left just after a falling edge.
  //   - Checks the current outputs, then drives the inputs.
  //   - Advances the model across the rising edge.
  task automatic step(input logic kv, input logic [3:0] k);
    logic [1:0] an_e;
    logic [3:0] nm_e;
    model_out(n_edges, an_e, nm_e);
    check_eq("anodes", {6'd0, bus.anodes}, {6'd0, an_e});
    check_eq("num", {4'd0, bus.num}, {4'd0, nm_e});
    check_eq("anodes_not_00", {7'd0, bus.anodes == 2'b00}, 8'd0);
    bus.key_valid = kv;
    bus.key_num   = k;
    @(posedge clk);
    n_edges++;
    if (kv) begin
      left_m  = right_m;
      right_m = k;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] an_e;
    logic [3:0] nm_e;
    int         guard;
    bus.key_valid = 1'b0;
    bus.key_num   = 4'h0;
    reset         = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state while reset is held.
    model_out(0, an_e, nm_e);
    check_eq("reset_anodes", {6'd0, bus.anodes}, {6'd0, an_e});
    check_eq("reset_num", {4'd0, bus.num}, 8'h00);
    reset   = 1'b0;
    n_edges = 0;

    // Key entry: 3 then A, followed by two full periods of display.
    step(1'b1, 4'h3);
    step(1'b1, 4'hA);
    for (int i = 0; i < 2 * P; i++) step(1'b0, 4'h0);

    // Key strobe on the edge that leaves the right digit's showing.
    guard = 0;
    while ((n_edges % P) != (B_EFF + R - 1) && guard < P) begin
      step(1'b0, 4'h0);
      guard++;
    end
    check_eq("align_show_r_end", {7'd0, guard < P}, 8'd1);
    step(1'b1, 4'h7);
    for (int i = 0; i < P + 3; i++) step(1'b0, 4'h0);

    // Random key traffic, including back-to-back strobes.
    for (int i = 0; i < 300; i++) begin
      step(($urandom % 4) == 0, 4'($urandom));
    end

    // Reset mid-operation, applied during the left digit's showing with
    // digits 5/9.
    step(1'b1, 4'h5);
    step(1'b1, 4'h9);
    guard = 0;
    while ((n_edges % P) < (2 * B_EFF + R) && guard < P) begin
      step(1'b0, 4'h0);
      guard++;
    end
    check_eq("align_show_l", {7'd0, guard < P}, 8'd1);
    check_eq("pre_reset_num", {4'd0, bus.num}, 8'h05);
    #2 reset = 1'b1;
    #1;
    model_out(0, an_e, nm_e);
    check_eq("async_reset_anodes", {6'd0, bus.anodes}, {6'd0, an_e});
    check_eq("async_reset_num", {4'd0, bus.num}, 8'h00);
    @(negedge clk);
    reset   = 1'b0;
    n_edges = 0;
    left_m  = 4'h0;
    right_m = 4'h0;
    for (int i = 0; i < P + 4; i++) step(1'b0, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end, got running expected finished");
    $fatal(1);
  end

endmodule
